// File: rtl/pingpong_playback_buffer_pkg.sv
// pingpong_pkg: shared types and helpers for the ping-pong playback buffer
package pingpong_pkg;
  typedef enum logic {RD_IDLE, RD_PLAY} rd_state_e;
  localparam int UNDERRUN_CNT_W = 16;
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/pingpong_playback_buffer_if.sv
// pingpong_playback_buffer_if: producer stream and playback strobe bundle
interface pingpong_playback_buffer_if #(parameter int WIDTH = 16);
  import pingpong_pkg::*;
  logic [WIDTH-1:0] wr_data_i;
  logic wr_valid_i;
  logic wr_ready_o;
  logic frame_loaded_o;
  logic sample_req_i;
  logic [WIDTH-1:0] sample_o;
  logic sample_valid_o;
  logic frame_start_o;
  logic underrun_o;
  logic [UNDERRUN_CNT_W-1:0] underrun_count_o;
  modport master (
    output wr_data_i, wr_valid_i, sample_req_i,
    input wr_ready_o, frame_loaded_o, sample_o, sample_valid_o, frame_start_o, underrun_o, underrun_count_o
  );
  modport slave (
    input wr_data_i, wr_valid_i, sample_req_i,
    output wr_ready_o, frame_loaded_o, sample_o, sample_valid_o, frame_start_o, underrun_o, underrun_count_o
  );
endinterface

// File: rtl/pingpong_playback_buffer_bank.sv
// pp_sp_bank: single-port synchronous RAM, read returns pre-write contents
module pp_sp_bank
  import pingpong_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic                      re_i,
  input  logic [addr_w(DEPTH)-1:0]  addr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  output logic [WIDTH-1:0]          rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/pingpong_playback_buffer.sv
// pingpong_playback_buffer: two-bank frame buffer, burst fill and strobed playback
module pingpong_playback_buffer
  import pingpong_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 256
) (
  input logic clk_i,
  input logic rst_ni,
  pingpong_playback_buffer_if.slave bus
);
  localparam int AW = addr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  rd_state_e state_q;
  logic [1:0] full_q, full_d;
  logic wr_bank_q, rd_bank_q, sel_q, zero_q;
  logic [AW-1:0] wr_addr_q, rd_addr_q;
  logic frame_loaded_q, sample_valid_q, frame_start_q, underrun_q;
  logic [UNDERRUN_CNT_W-1:0] cnt_q;
  logic wr_fire, rd_fire, und, wr_last, rd_last;
  logic [WIDTH-1:0] rdata [2];
  assign bus.wr_ready_o = !full_q[wr_bank_q] && rst_ni;
  assign wr_fire = bus.wr_valid_i && bus.wr_ready_o;
  assign rd_fire = bus.sample_req_i && full_q[rd_bank_q];
  assign und = bus.sample_req_i && !full_q[rd_bank_q] && state_q == RD_IDLE;
  assign wr_last = wr_addr_q == LAST;
  assign rd_last = rd_addr_q == LAST;
  // a full bank belongs to the reader, an empty one to the writer
  for (genvar b = 0; b < 2; b++) begin : g_bank
    pp_sp_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bank (
      .clk_i   (clk_i),
      .we_i    (wr_fire && wr_bank_q == 1'(b)),
      .re_i    (rd_fire && rd_bank_q == 1'(b)),
      .addr_i  (full_q[b] ? rd_addr_q : wr_addr_q),
      .wdata_i (bus.wr_data_i),
      .rdata_o (rdata[b])
    );
  end
  always_comb begin
    full_d = full_q;
    if (wr_fire && wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_fire && rd_last) full_d[rd_bank_q] = 1'b0;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= RD_IDLE;
      full_q         <= '0;
      wr_bank_q      <= 1'b0;
      rd_bank_q      <= 1'b0;
      sel_q          <= 1'b0;
      zero_q         <= 1'b1;
      wr_addr_q      <= '0;
      rd_addr_q      <= '0;
      frame_loaded_q <= 1'b0;
      sample_valid_q <= 1'b0;
      frame_start_q  <= 1'b0;
      underrun_q     <= 1'b0;
      cnt_q          <= '0;
    end else begin
      full_q         <= full_d;
      frame_loaded_q <= wr_fire && wr_last;
      sample_valid_q <= rd_fire || und;
      frame_start_q  <= rd_fire && rd_addr_q == '0;
      underrun_q     <= und;
      if (wr_fire) begin
        wr_addr_q <= wr_last ? '0 : wr_addr_q + 1'b1;
        wr_bank_q <= wr_last ? !wr_bank_q : wr_bank_q;
      end
      if (und) begin
        zero_q <= 1'b1;
        cnt_q  <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      end
      if (rd_fire) begin
        zero_q    <= 1'b0;
        sel_q     <= rd_bank_q;
        rd_addr_q <= rd_last ? '0 : rd_addr_q + 1'b1;
        rd_bank_q <= rd_last ? !rd_bank_q : rd_bank_q;
        state_q   <= (rd_last && !full_q[!rd_bank_q]) ? RD_IDLE : RD_PLAY;
      end
    end
  end
  assign bus.sample_o         = zero_q ? '0 : rdata[sel_q];
  assign bus.sample_valid_o   = sample_valid_q;
  assign bus.frame_start_o    = frame_start_q;
  assign bus.underrun_o       = underrun_q;
  assign bus.frame_loaded_o   = frame_loaded_q;
  assign bus.underrun_count_o = cnt_q;
endmodule

// File: doc/pingpong_playback_buffer.md
# pingpong_playback_buffer

Ping-pong frame buffer for the transmit/playback direction, the counterpart of the capture ping-pong buffer. It accepts whole frames in bursts from a block producer (IFFT or frame generator) over a valid/ready stream. It plays them out one sample per sample strobe to the DAC/output path. Two single-port banks alternate: one fills while the other drains, and each bank is only ever written or read, never both.

## Interface
- WIDTH, 16, sample width in bits
- DEPTH, 256, samples per frame; power of two, 2..1024
- clk_i  input  1  system clock
- rst_ni  input  1  synchronous, active-low reset
- wr_data_i  input  WIDTH  producer sample
- wr_valid_i  input  1  producer sample valid
- wr_ready_o  output  1  fill bank free; a transfer occurs on wr_valid_i && wr_ready_o
- frame_loaded_o  output  1  one-cycle pulse after the last sample of a frame is written
- sample_req_i  input  1  playback strobe, at most one per cycle
- sample_o  output  WIDTH  played sample, held between strobes
- sample_valid_o  output  1  one-cycle pulse, sample_o updated
- frame_start_o  output  1  pulses with sample_valid_o for sample 0 of a frame
- underrun_o  output  1  pulses with sample_valid_o when no frame was available
- underrun_count_o  output  16  saturating count of underruns

## Operation
- State:
  - full[1:0] per-bank flags
  - wr_bank and wr_addr for the fill side
  - rd_bank and rd_addr for the drain side
  - AW = $clog2(DEPTH)
- Write side:
  - wr_ready_o = !full[wr_bank] && rst_ni.
  - On a transfer, write bank[wr_bank][wr_addr] and increment wr_addr.
  - At wr_addr == DEPTH-1: set full[wr_bank], toggle wr_bank, set wr_addr to 0, pulse frame_loaded_o next cycle.
- Read FSM, IDLE / PLAY:
  - IDLE: on sample_req_i with full[rd_bank]=1, read bank[rd_bank][rd_addr] and go to PLAY. With full[rd_bank]=0, it is an underrun.
  - PLAY: each sample_req_i reads rd_addr, then increments it.
  - At rd_addr == DEPTH-1: clear full[rd_bank], toggle rd_bank, set rd_addr to 0. Stay in PLAY if full of the other bank, otherwise go to IDLE.
- Underrun: sample_req_i in IDLE with no full bank.
  - Next cycle, sample_valid_o=1, sample_o=0 and underrun_o=1.
  - underrun_count_o increments and saturates at 16'hFFFF.
  - No address moves.
- Bank exclusivity: the writer only addresses !full banks and the reader only addresses full banks, so each bank has a single port owner per cycle.
- Bank address mux:
  - Address = write address when the bank is not full, read address when it is full.
  - WRE = transfer && bank == wr_bank.
- Simultaneous set and clear of full flags on different banks in one cycle are both applied.
- A freed bank becomes writable the following cycle.
- The writer is never stalled by reads, and the reader is never stalled by writes.

## Timing
- Reset values:
  - all outputs 0, including wr_ready_o while rst_ni=0
  - full=0, pointers 0, FSM IDLE, counter 0
- wr_ready_o=1 on the first cycle after reset.
- Reset mid-frame discards partial and full frames. No output pulses in the reset cycle or the cycle after.
- Read latency: sample_valid_o, sample_o and frame_start_o are valid exactly 1 cycle after sample_req_i. sample_o is sourced from the synchronous RAM output.
- Write-to-play: the earliest valid play request is the cycle after the last write. A request in the same cycle as the last write is an underrun.
- frame_loaded_o comes 1 cycle after the final transfer.
- Back-to-back requests every cycle are supported, so throughput is 1 sample/cycle on each side.

## Structure
- Package pingpong_pkg holds:
  - read FSM state enum (RD_IDLE, RD_PLAY)
  - UNDERRUN_CNT_W = 16
  - shared AW helper
- One sub-module, pp_sp_bank: inferred single-port synchronous RAM, WIDTH x DEPTH, with write-first disabled (read returns old data). It is instantiated twice.

## Test plan
- Reset then load samples 0..DEPTH-1 as a ramp -> frame_loaded_o pulses once; wr_ready_o stays 1 for bank 1. DEPTH strobes then return 0..DEPTH-1 in order, frame_start_o on the first only.
- Load two frames A and B without strobes -> wr_ready_o drops after the 2*DEPTH-th transfer. The first play-out is A then B with no gap, and wr_ready_o rises 1 cycle after A's last read.
- Strobe with no frame loaded -> sample_o=0, underrun_o=1, count=1. Then load a frame: the next strobe returns sample 0 with frame_start_o.
- Strobe every cycle while the producer writes every cycle (DEPTH=8) -> no underruns after priming and no lost or duplicated samples, checked against a scoreboard.
- Assert rst_ni low mid-fill and mid-play -> all outputs 0, wr_ready_o=1 one cycle after release, next frame plays from sample 0.
- Force 65536 underruns -> underrun_count_o saturates at 16'hFFFF.
